instr_fetch_stage: RTL and testbench

//  Fetch stage + IF/ID register for the 2-bit-tipo core. Owns the PC and drives instruction-memory requests.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/fetch_skid_buf.sv | 55 +++++
 rtl/instr_fetch_stage.sv | 199 +++++++++++++++++++
 tb/tb_instr_fetch_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and field positions for the instruction fetch stage.
// Contents:
//   tipo_t        : instruction class encoded in instr[31:30]
//   TIPO_MSB, OP_MSB, INM_BIT : field positions inside a 32-bit instruction
//   fetch_state_t : request FSM states
//   fetch_active  : true in the states that drive imem_req
package fetch_pkg;

  typedef enum logic [1:0] {
    TIPO_R = 2'b00,
    TIPO_I = 2'b01,
    TIPO_S = 2'b10,
    TIPO_B = 2'b11
  } tipo_t;

  localparam int TIPO_MSB = 31;
  localparam int OP_MSB   = 29;
  localparam int INM_BIT  = 27;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Both REQ and DRAIN keep a request open on the memory port; DRAIN only
  // differs in that the returning word is thrown away.
  function automatic logic fetch_active(input fetch_state_t s);
    return (s == REQ) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer used when IF/ID is stalled while a
// fetched word is arriving.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (clears full flag)
//   push_i     : capture instr_i/pc_i (only issued while empty)
//   pop_i      : entry consumed by IF/ID
//   clear_i    : discard entry (branch flush); wins over push/pop
//   instr_i/pc_i : word and its address to store
//   full_o     : buffer holds an entry
//   instr_o/pc_o : stored word and address
module fetch_skid_buf #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               full_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o
);

  logic               full_q, full_d;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;

  always_comb begin
    full_d = full_q;
    if (clear_i)     full_d = 1'b0;
    else if (push_i) full_d = 1'b1;
    else if (pop_i)  full_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) full_q <= 1'b0;
    else     full_q <= full_d;
  end

  // Payload is qualified by full_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage plus IF/ID register for the 2-bit-tipo core. Owns the PC,
// issues instruction-memory requests and presents one registered
// instruction with its tipo/op/Inm fields split out for the decoder.
// Stall back-pressure is absorbed by a one-entry skid buffer; a taken branch
// flushes IF/ID and the skid and redirects the PC.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   stall                     : downstream not consuming, hold IF/ID
//   branch_taken/branch_target: flush and redirect fetch
//   imem_req/imem_addr        : request, address held until imem_ready
//   imem_ready/imem_rdata     : request completion and returned word
//   id_valid/id_instr/id_pc   : IF/ID contents
//   id_tipo/id_op/id_inm      : field slices of id_instr
//   perf_fetch_cnt/perf_bubble_cnt : only with FETCH_PERF_CNT_EN defined;
//     words loaded into IF/ID and cycles with empty IF/ID and no stall.
// Build option: `define FETCH_PERF_CNT_EN to add the performance counters.
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          INSTR_W  = 32,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [1:0]         id_tipo,
  output logic [1:0]         id_op,
  output logic               id_inm
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(PC_STEP);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [ADDR_W-1:0]  id_pc_q, id_pc_d;

  logic               skid_full, skid_full_nxt;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;

  logic accept;   // word returned for the current pc and kept
  logic id_upd;   // IF/ID may take a new value this edge
  logic push;
  logic pop;
  logic id_load;

  // The skid is only ever filled from REQ, and REQ is only entered with the
  // skid empty, so push and pop never coincide.
  assign accept = (state_q == REQ) && imem_ready && !branch_taken;
  assign id_upd = !stall || !id_valid_q;
  assign push   = accept && !id_upd;
  assign pop    = id_upd && skid_full && !branch_taken;
  assign id_load = !branch_taken && id_upd && (skid_full || accept);

  always_comb begin
    skid_full_nxt = skid_full;
    if (branch_taken) skid_full_nxt = 1'b0;
    else if (push)    skid_full_nxt = 1'b1;
    else if (pop)     skid_full_nxt = 1'b0;
  end

  fetch_skid_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (branch_taken),
    .instr_i (imem_rdata),
    .pc_i    (pc_q),
    .full_o  (skid_full),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  // Request FSM and PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (branch_taken) pc_d = branch_target;
        if (!skid_full_nxt) state_d = REQ;
      end
      REQ: begin
        if (imem_ready) begin
          if (branch_taken) begin
            pc_d    = branch_target;
            state_d = REQ;
          end else begin
            pc_d    = pc_q + STEP;
            state_d = skid_full_nxt ? IDLE : REQ;
          end
        end else if (branch_taken) begin
          pc_d    = branch_target;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (branch_taken) pc_d = branch_target;
        if (imem_ready) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    // The address only moves when a new request starts; in DRAIN it stays
    // on the abandoned address while pc already points at the target.
    if (state_d == REQ) addr_d = pc_d;
  end

  // IF/ID register next state.
  always_comb begin
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    if (branch_taken) begin
      id_valid_d = 1'b0;
    end else if (id_upd) begin
      if (skid_full) begin
        id_valid_d = 1'b1;
        id_instr_d = skid_instr;
        id_pc_d    = skid_pc;
      end else if (accept) begin
        id_valid_d = 1'b1;
        id_instr_d = imem_rdata;
        id_pc_d    = pc_q;
      end else begin
        id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RST_PC;
      addr_q     <= RST_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

  assign imem_req  = fetch_active(state_q);
  assign imem_addr = addr_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_tipo   = id_instr_q[TIPO_MSB -: 2];
  assign id_op     = id_instr_q[OP_MSB -: 2];
  assign id_inm    = id_instr_q[INM_BIT];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (id_load)               fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (!id_valid_q && !stall) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios followed by random
// ready/stall/branch traffic checked against a stream-level model
// (expected delivery address, memory contents as a function of address).
module tb_instr_fetch_stage;

  localparam int AW = 32;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ready;
  logic [IW-1:0] imem_rdata;
  logic          id_valid;
  logic [IW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic [1:0]    id_tipo;
  logic [1:0]    id_op;
  logic          id_inm;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_fetch_cnt;
  logic [31:0]   perf_bubble_cnt;
  int            m_fetch;
  int            m_bubble;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata = memw(imem_addr);

  instr_fetch_stage #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .RESET_PC (0),
    .PC_STEP  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_tipo       (id_tipo),
    .id_op         (id_op),
    .id_inm        (id_inm)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model state: next address the decoder must see, plus last-cycle snapshot.
  logic [31:0] exp_pc;
  int          consumed;
  logic        p_ok, p_valid, p_stall, p_branch, p_req, p_ready;
  logic [31:0] p_addr, p_pc, p_instr;

  // Drive inputs for one cycle (caller sits 1 time unit after a rising edge),
  // check/update the model at the falling edge, return 1 unit after the next
  // rising edge.
  task automatic step(input logic rd, input logic st, input logic br, input logic [31:0] tg);
    logic [31:0] e;
    imem_ready    = rd;
    stall         = st;
    branch_taken  = br;
    branch_target = tg;
    @(negedge clk);
    if (rst) begin
      exp_pc = 32'h0;
      p_ok   = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      m_fetch  = 0;
      m_bubble = 0;
`endif
    end else begin
      if (p_ok && p_req && !p_ready) begin
        chk("req_held", imem_req, 1'b1);
        chk("addr_held", imem_addr, p_addr);
      end
      if (p_ok && p_valid && p_stall && !p_branch) begin
        chk("stall_valid", id_valid, 1'b1);
        chk("stall_pc", id_pc, p_pc);
        chk("stall_instr", id_instr, p_instr);
      end
`ifdef FETCH_PERF_CNT_EN
      if (id_valid && !(p_ok && p_valid && p_stall && !p_branch)) m_fetch++;
      chk("perf_fetch", perf_fetch_cnt, 32'(m_fetch));
      chk("perf_bubble", perf_bubble_cnt, 32'(m_bubble));
      if (!id_valid && !stall) m_bubble++;
`endif
      if (branch_taken) begin
        exp_pc = branch_target;
      end else if (id_valid && !stall) begin
        e = memw(exp_pc);
        chk("id_pc", id_pc, exp_pc);
        chk("id_instr", id_instr, e);
        chk("id_tipo", id_tipo, e[31:30]);
        chk("id_op", id_op, e[29:28]);
        chk("id_inm", id_inm, e[27]);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      p_ok     = 1'b1;
      p_valid  = id_valid;
      p_stall  = stall;
      p_branch = branch_taken;
      p_req    = imem_req;
      p_ready  = imem_ready;
      p_addr   = imem_addr;
      p_pc     = id_pc;
      p_instr  = id_instr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("rst_perf_bubble", perf_bubble_cnt, 32'h0);
`endif
  endtask

  logic [31:0] a0;

  initial begin
    consumed      = 0;
    p_ok          = 1'b0;
    exp_pc        = 32'h0;
    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    imem_ready    = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk_reset_vals();

    // Zero-wait memory streams one word per cycle after release.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("t1_addr", imem_addr, 32'(4 * i));
      chk("t1_req", imem_req, 1'b1);
      if (i > 0) begin
        chk("t1_valid", id_valid, 1'b1);
        chk("t1_idpc", id_pc, 32'(4 * (i - 1)));
      end
    end

    // Branch coincident with ready and stall.
    step(1'b1, 1'b1, 1'b1, 32'h40);
    chk("t5_valid", id_valid, 1'b0);
    chk("t5_addr", imem_addr, 32'h40);
    chk("t5_req", imem_req, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t5_skid_empty", id_valid, 1'b0);

    // Branch while a request waits: address held, word dropped.
    step(1'b0, 1'b0, 1'b1, 32'h100);
    chk("t4_addr_hold", imem_addr, 32'h40);
    chk("t4_req", imem_req, 1'b1);
    chk("t4_valid", id_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t4_addr_hold2", imem_addr, 32'h40);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t4_redirect", imem_addr, 32'h100);
    chk("t4_valid2", id_valid, 1'b0);

    // Stall for three cycles with ready high.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("t3_idpc", id_pc, 32'h100);
      chk("t3_req", imem_req, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

    // Two wait states per word.
    for (int k = 0; k < 3; k++) begin
      a0 = imem_addr;
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t2_hold1", imem_addr, a0);
      chk("t2_nopulse", id_valid, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t2_hold2", imem_addr, a0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("t2_next", imem_addr, a0 + 32'd4);
      chk("t2_pulse", id_valid, 1'b1);
      chk("t2_pulse_pc", id_pc, a0);
    end

    // Reset asserted mid-wait acts without a clock edge.
    step(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    chk_reset_vals();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t6_first_addr", imem_addr, 32'h0);
    chk("t6_first_req", imem_req, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 4,
           $urandom & 32'h0003_FFFC);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("liveness", consumed > 300, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
